// File: rtl/axi_mem_responder.sv
// AXI4 memory responder: on-chip word array serving one write and one read burst at a time (INCR, full width).
// Latency: B is asserted RESP_DELAY+1 cycles after the last W beat; the first R beat is asserted RESP_DELAY+1 cycles after AR.
// Backpressure: B and R are held stable until they are accepted, with no timeout; AW and AR are refused while their burst is busy.
module axi_mem_responder #(
    parameter int ID_W       = 6,
    parameter int ADDR_W     = 49,
    parameter int DATA_W     = 128,
    parameter int DEPTH      = 1024,
    parameter int RESP_DELAY = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ID_W-1:0]     mem_awid,
    input  logic [ADDR_W-1:0]   mem_awaddr,
    input  logic [7:0]          mem_awlen,
    input  logic                mem_awvalid,
    output logic                mem_awready,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_wlast,
    input  logic                mem_wvalid,
    output logic                mem_wready,
    output logic [ID_W-1:0]     mem_bid,
    output logic [1:0]          mem_bresp,
    output logic                mem_bvalid,
    input  logic                mem_bready,
    input  logic [ID_W-1:0]     mem_arid,
    input  logic [ADDR_W-1:0]   mem_araddr,
    input  logic [7:0]          mem_arlen,
    input  logic                mem_arvalid,
    output logic                mem_arready,
    output logic [ID_W-1:0]     mem_rid,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic [1:0]          mem_rresp,
    output logic                mem_rlast,
    output logic                mem_rvalid,
    input  logic                mem_rready
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    // A zero delay skips the delay states entirely; otherwise the delay counter runs 0..RESP_DELAY-1.
    localparam bit NO_DLY = (RESP_DELAY == 0);
    localparam int DLY_W  = (RESP_DELAY > 2) ? $clog2(RESP_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(NO_DLY ? 0 : RESP_DELAY - 1);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_DLY  = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_DLY  = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    logic [DATA_W-1:0] mem_array [DEPTH];

    logic [1:0]        wstate;
    logic [ID_W-1:0]   wid_q;
    logic [IDX_W-1:0]  widx;
    logic [7:0]        wlen;
    logic [7:0]        wcnt;
    logic              werr;
    logic [DLY_W-1:0]  wdly;
    logic [DATA_W-1:0] wmerge;
    logic              w_fire;

    logic [1:0]        rstate;
    logic [ID_W-1:0]   rid_q;
    logic [IDX_W-1:0]  ridx;
    logic [7:0]        rlen;
    logic [7:0]        rcnt;
    logic [DLY_W-1:0]  rdly;
    logic [DATA_W-1:0] rdata_q;
    logic [IDX_W-1:0]  ar_idx;

    // Byte offset and address bits above the array index carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, mem_awaddr[OFF-1:0], mem_awaddr[ADDR_W-1:OFF+IDX_W],
                                mem_araddr[OFF-1:0], mem_araddr[ADDR_W-1:OFF+IDX_W]};

    // Word index advance, wrapping at the top of the array.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(DEPTH - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    assign ar_idx = mem_araddr[OFF +: IDX_W];

    assign mem_awready = (wstate == W_IDLE) && !reset;
    assign mem_wready  = (wstate == W_DATA) && !reset;
    assign mem_bvalid  = (wstate == W_RESP) && !reset;
    assign mem_bid     = mem_bvalid ? wid_q : '0;
    assign mem_bresp   = (mem_bvalid && werr) ? 2'b10 : 2'b00;
    assign w_fire      = mem_wvalid && mem_wready;

    assign mem_arready = (rstate == R_IDLE) && !reset;
    assign mem_rvalid  = (rstate == R_DATA) && !reset;
    assign mem_rid     = mem_rvalid ? rid_q : '0;
    assign mem_rlast   = mem_rvalid && (rcnt == rlen);
    assign mem_rresp   = 2'b00;
    assign mem_rdata   = rdata_q;

    // Overlay the strobed bytes of the current beat onto the addressed word.
    always_comb begin
        wmerge = mem_array[widx];
        for (int b = 0; b < BYTES; b++) begin
            if (mem_wstrb[b]) begin
                wmerge[b*8 +: 8] = mem_wdata[b*8 +: 8];
            end
        end
    end

    // Array contents survive reset; only accepted W beats modify them.
    always_ff @(posedge clock) begin
        if (w_fire) begin
            mem_array[widx] <= wmerge;
        end
    end

    // Write burst sequencing: address accept, beat counting, response delay, B handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            wstate <= W_IDLE;
            wid_q  <= '0;
            widx   <= '0;
            wlen   <= '0;
            wcnt   <= '0;
            werr   <= 1'b0;
            wdly   <= '0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (mem_awvalid) begin
                        wid_q  <= mem_awid;
                        widx   <= mem_awaddr[OFF +: IDX_W];
                        wlen   <= mem_awlen;
                        wcnt   <= '0;
                        werr   <= 1'b0;
                        wstate <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        widx <= idx_inc(widx);
                        wcnt <= wcnt + 8'd1;
                        // The burst length, not wlast, decides when the burst ends.
                        if (mem_wlast != (wcnt == wlen)) begin
                            werr <= 1'b1;
                        end
                        if (wcnt == wlen) begin
                            wdly   <= '0;
                            wstate <= NO_DLY ? W_RESP : W_DLY;
                        end
                    end
                end
                W_DLY: begin
                    if (wdly == DLY_LAST) begin
                        wstate <= W_RESP;
                    end else begin
                        wdly <= wdly + DLY_W'(1);
                    end
                end
                W_RESP: begin
                    if (mem_bready) begin
                        wstate <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read burst sequencing; rdata is registered so it stays put while R is stalled,
    // and a same-cycle write to the fetched word is seen only by later beats.
    always_ff @(posedge clock) begin
        if (reset) begin
            rstate  <= R_IDLE;
            rid_q   <= '0;
            ridx    <= '0;
            rlen    <= '0;
            rcnt    <= '0;
            rdly    <= '0;
            rdata_q <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (mem_arvalid) begin
                        rid_q <= mem_arid;
                        ridx  <= ar_idx;
                        rlen  <= mem_arlen;
                        rcnt  <= '0;
                        rdly  <= '0;
                        if (NO_DLY) begin
                            rdata_q <= mem_array[ar_idx];
                            rstate  <= R_DATA;
                        end else begin
                            rstate  <= R_DLY;
                        end
                    end
                end
                R_DLY: begin
                    if (rdly == DLY_LAST) begin
                        rdata_q <= mem_array[ridx];
                        rstate  <= R_DATA;
                    end else begin
                        rdly <= rdly + DLY_W'(1);
                    end
                end
                R_DATA: begin
                    if (mem_rready) begin
                        if (rcnt == rlen) begin
                            rstate <= R_IDLE;
                        end else begin
                            ridx    <= idx_inc(ridx);
                            rcnt    <= rcnt + 8'd1;
                            rdata_q <= mem_array[idx_inc(ridx)];
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: reset state, single and wrapped bursts, strobes, wlast errors, mid-burst reset.
// Latency: expectations are hand-computed cycle counts relative to each handshake.
// Backpressure: R is stalled for several cycles to verify hold behaviour; every wait is bounded.
module tb_axi_mem_responder;

    localparam int LIMIT = 40;

    logic         clock = 1'b0;
    logic         reset;
    logic [5:0]   mem_awid;
    logic [48:0]  mem_awaddr;
    logic [7:0]   mem_awlen;
    logic         mem_awvalid;
    logic         mem_awready;
    logic [127:0] mem_wdata;
    logic [15:0]  mem_wstrb;
    logic         mem_wlast;
    logic         mem_wvalid;
    logic         mem_wready;
    logic [5:0]   mem_bid;
    logic [1:0]   mem_bresp;
    logic         mem_bvalid;
    logic         mem_bready;
    logic [5:0]   mem_arid;
    logic [48:0]  mem_araddr;
    logic [7:0]   mem_arlen;
    logic         mem_arvalid;
    logic         mem_arready;
    logic [5:0]   mem_rid;
    logic [127:0] mem_rdata;
    logic [1:0]   mem_rresp;
    logic         mem_rlast;
    logic         mem_rvalid;
    logic         mem_rready;

    int passed = 0;
    int total  = 0;

    localparam logic [127:0] D_BEEF = 128'h0123_4567_89AB_CDEF_0011_2233_DEAD_BEEF;
    localparam logic [127:0] D_A    = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] D_B    = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
    localparam logic [127:0] D_C    = 128'hCCCC_1111_CCCC_2222_CCCC_3333_CCCC_4444;

    axi_mem_responder dut (
        .clock       (clock),
        .reset       (reset),
        .mem_awid    (mem_awid),
        .mem_awaddr  (mem_awaddr),
        .mem_awlen   (mem_awlen),
        .mem_awvalid (mem_awvalid),
        .mem_awready (mem_awready),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_wlast   (mem_wlast),
        .mem_wvalid  (mem_wvalid),
        .mem_wready  (mem_wready),
        .mem_bid     (mem_bid),
        .mem_bresp   (mem_bresp),
        .mem_bvalid  (mem_bvalid),
        .mem_bready  (mem_bready),
        .mem_arid    (mem_arid),
        .mem_araddr  (mem_araddr),
        .mem_arlen   (mem_arlen),
        .mem_arvalid (mem_arvalid),
        .mem_arready (mem_arready),
        .mem_rid     (mem_rid),
        .mem_rdata   (mem_rdata),
        .mem_rresp   (mem_rresp),
        .mem_rlast   (mem_rlast),
        .mem_rvalid  (mem_rvalid),
        .mem_rready  (mem_rready)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance past the next rising edge; all sampling and driving happens 1ns later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_aw(input logic [5:0] id, input logic [48:0] addr, input logic [7:0] len);
        int n;
        mem_awid    = id;
        mem_awaddr  = addr;
        mem_awlen   = len;
        mem_awvalid = 1'b1;
        n = 0;
        while (!mem_awready && n < LIMIT) begin
            tick();
            n++;
        end
        check("aw_handshake", 128'(mem_awready), 128'd1);
        tick();
        mem_awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [127:0] data, input logic [15:0] strb, input logic last);
        int n;
        mem_wdata  = data;
        mem_wstrb  = strb;
        mem_wlast  = last;
        mem_wvalid = 1'b1;
        n = 0;
        while (!mem_wready && n < LIMIT) begin
            tick();
            n++;
        end
        check("w_handshake", 128'(mem_wready), 128'd1);
        tick();
        mem_wvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [5:0] id, input logic [48:0] addr, input logic [7:0] len);
        int n;
        mem_arid    = id;
        mem_araddr  = addr;
        mem_arlen   = len;
        mem_arvalid = 1'b1;
        n = 0;
        while (!mem_arready && n < LIMIT) begin
            tick();
            n++;
        end
        check("ar_handshake", 128'(mem_arready), 128'd1);
        tick();
        mem_arvalid = 1'b0;
    endtask

    // Called in the cycle right after the handshake, so that cycle counts as 1.
    task automatic wait_b(output int cyc);
        cyc = 1;
        while (!mem_bvalid && cyc < LIMIT) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_r(output int cyc);
        cyc = 1;
        while (!mem_rvalid && cyc < LIMIT) begin
            tick();
            cyc++;
        end
    endtask

    task automatic ack_b();
        mem_bready = 1'b1;
        tick();
        mem_bready = 1'b0;
    endtask

    initial begin
        int cyc;
        logic stable;
        logic seen;
        logic [135:0] snap;

        reset       = 1'b1;
        mem_awid    = '0;
        mem_awaddr  = '0;
        mem_awlen   = '0;
        mem_awvalid = 1'b0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        mem_wlast   = 1'b0;
        mem_wvalid  = 1'b0;
        mem_bready  = 1'b0;
        mem_arid    = '0;
        mem_araddr  = '0;
        mem_arlen   = '0;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;

        // Reset for 5 cycles: readies and valids low.
        repeat (5) tick();
        check("rst_awready", 128'(mem_awready), 128'd0);
        check("rst_arready", 128'(mem_arready), 128'd0);
        check("rst_bvalid",  128'(mem_bvalid),  128'd0);
        check("rst_rvalid",  128'(mem_rvalid),  128'd0);
        reset = 1'b0;
        tick();
        check("post_awready", 128'(mem_awready), 128'd1);
        check("post_arready", 128'(mem_arready), 128'd1);
        check("post_bvalid",  128'(mem_bvalid),  128'd0);
        check("post_rvalid",  128'(mem_rvalid),  128'd0);
        check("post_wready",  128'(mem_wready),  128'd0);

        // Single-beat write: B five cycles after the W beat.
        do_aw(6'd3, 49'h20, 8'd0);
        check("aw_busy", 128'(mem_awready), 128'd0);
        do_w(D_BEEF, 16'hFFFF, 1'b1);
        wait_b(cyc);
        check("b_latency", 128'(cyc), 128'd5);
        check("b_id",   128'(mem_bid),   128'd3);
        check("b_resp", 128'(mem_bresp), 128'd0);
        ack_b();
        check("b_drop", 128'(mem_bvalid), 128'd0);
        check("b_awready", 128'(mem_awready), 128'd1);

        // Single-beat read with R stalled for 10 cycles.
        do_ar(6'd5, 49'h20, 8'd0);
        wait_r(cyc);
        check("r_latency", 128'(cyc), 128'd5);
        check("r_data", mem_rdata, D_BEEF);
        check("r_id",   128'(mem_rid),   128'd5);
        check("r_last", 128'(mem_rlast), 128'd1);
        check("r_resp", 128'(mem_rresp), 128'd0);
        snap = {mem_rdata, mem_rid, mem_rlast, mem_rvalid};
        stable = 1'b1;
        repeat (10) begin
            tick();
            if ({mem_rdata, mem_rid, mem_rlast, mem_rvalid} !== snap) stable = 1'b0;
        end
        check("r_hold", 128'(stable), 128'd1);
        mem_rready = 1'b1;
        tick();
        mem_rready = 1'b0;
        check("r_drop", 128'(mem_rvalid), 128'd0);

        // Two-beat write wrapping from word 1023 to word 0, then read back.
        do_aw(6'd9, 49'h3FF0, 8'd1);
        do_w(D_A, 16'hFFFF, 1'b0);
        check("wrap_wready", 128'(mem_wready), 128'd1);
        do_w(D_B, 16'hFFFF, 1'b1);
        wait_b(cyc);
        check("wrap_b_latency", 128'(cyc), 128'd5);
        check("wrap_b_resp", 128'(mem_bresp), 128'd0);
        ack_b();
        do_ar(6'd10, 49'h3FF0, 8'd1);
        wait_r(cyc);
        check("wrap_r_latency", 128'(cyc), 128'd5);
        check("wrap_r0_data", mem_rdata, D_A);
        check("wrap_r0_last", 128'(mem_rlast), 128'd0);
        mem_rready = 1'b1;
        tick();
        check("wrap_r1_valid", 128'(mem_rvalid), 128'd1);
        check("wrap_r1_data",  mem_rdata, D_B);
        check("wrap_r1_last",  128'(mem_rlast), 128'd1);
        check("wrap_r1_id",    128'(mem_rid),   128'd10);
        tick();
        mem_rready = 1'b0;
        check("wrap_r_drop", 128'(mem_rvalid), 128'd0);

        // Partial strobe over a zeroed word 0.
        do_aw(6'd1, 49'h0, 8'd0);
        do_w(128'd0, 16'hFFFF, 1'b1);
        wait_b(cyc);
        ack_b();
        do_aw(6'd1, 49'h0, 8'd0);
        do_w({128{1'b1}}, 16'h000F, 1'b1);
        wait_b(cyc);
        ack_b();
        do_ar(6'd2, 49'h0, 8'd0);
        wait_r(cyc);
        check("strb_data", mem_rdata, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
        mem_rready = 1'b1;
        tick();
        mem_rready = 1'b0;

        // wlast on the first of two beats: both beats consumed, SLVERR.
        do_aw(6'd12, 49'h40, 8'd1);
        do_w(D_A, 16'hFFFF, 1'b1);
        check("err_still_wready", 128'(mem_wready), 128'd1);
        check("err_no_bvalid",    128'(mem_bvalid), 128'd0);
        do_w(D_B, 16'hFFFF, 1'b0);
        wait_b(cyc);
        check("err_b_latency", 128'(cyc), 128'd5);
        check("err_b_resp", 128'(mem_bresp), 128'd2);
        check("err_b_id",   128'(mem_bid),   128'd12);
        ack_b();

        // Reset after one of four beats: burst dropped, beat kept.
        do_aw(6'd7, 49'h100, 8'd3);
        do_w(D_C, 16'hFFFF, 1'b0);
        reset = 1'b1;
        tick();
        check("mid_rst_wready", 128'(mem_wready), 128'd0);
        tick();
        reset = 1'b0;
        tick();
        check("mid_rst_awready", 128'(mem_awready), 128'd1);
        check("mid_rst_wready_after", 128'(mem_wready), 128'd0);
        seen = 1'b0;
        repeat (10) begin
            if (mem_bvalid) seen = 1'b1;
            tick();
        end
        check("mid_rst_no_b", 128'(seen), 128'd0);
        do_ar(6'd4, 49'h100, 8'd0);
        wait_r(cyc);
        check("mid_rst_kept", mem_rdata, D_C);
        mem_rready = 1'b1;
        tick();
        mem_rready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
